// File: rtl/hazard_if.sv
// hazard_if: pipeline hazard signals between the datapath and the hazard controller
interface hazard_if;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, LoadE, PCSrcE, MDStartE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, LoadE, PCSrcE, MDStartE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, StallCount
    );
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW, LoadE, PCSrcE, MDStartE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, StallCount
    );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: forwarding, load-use/branch hazards and multi-cycle op stalls for a 5-stage pipeline
module hazard_controller #(
    parameter int MD_LAT = 4
) (
    input logic clk,
    input logic rst,
    hazard_if.slave h
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, LAST = 2'd2;
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [15:0] stall_count;
    logic        lw_stall, md_stall, stall_f;
    always_comb begin
        lw_stall = h.LoadE && h.RdE != 5'd0 && (h.RdE == h.Rs1D || h.RdE == h.Rs2D);
        md_stall = (state == IDLE && h.MDStartE) || state == BUSY;
        // every hazard output is forced quiet while reset is held
        stall_f = rst && (md_stall || lw_stall);
        h.StallF = stall_f;
        h.StallD = stall_f;
        h.StallE = rst && md_stall;
        h.FlushM = rst && md_stall;
        h.FlushD = rst && !md_stall && h.PCSrcE;
        h.FlushE = rst && !md_stall && (lw_stall || h.PCSrcE);
        h.ForwardAE = !rst ? 2'b00 :
                      (h.RegWriteM && h.RdM != 5'd0 && h.RdM == h.Rs1E) ? 2'b10 :
                      (h.RegWriteW && h.RdW != 5'd0 && h.RdW == h.Rs1E) ? 2'b01 : 2'b00;
        h.ForwardBE = !rst ? 2'b00 :
                      (h.RegWriteM && h.RdM != 5'd0 && h.RdM == h.Rs2E) ? 2'b10 :
                      (h.RegWriteW && h.RdW != 5'd0 && h.RdW == h.Rs2E) ? 2'b01 : 2'b00;
        h.StallCount = stall_count;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            stall_count <= 16'd0;
        end else begin
            state <= (state == IDLE) ? (h.MDStartE ? ((MD_LAT > 2) ? BUSY : LAST) : IDLE) :
                     (state == BUSY) ? ((cnt == 4'd1) ? LAST : BUSY) : IDLE;
            cnt   <= (state == IDLE && h.MDStartE) ? 4'(MD_LAT - 2) :
                     (state == BUSY && cnt != 4'd1) ? cnt - 4'd1 : 4'd0;
            if (stall_f && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors feed a scoreboard queue; a monitor checks two controller instances
module tb_hazard_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    hazard_if h4 ();
    hazard_if h2 ();
    hazard_controller #(.MD_LAT(4)) dut4 (.clk(clk), .rst(rst), .h(h4.slave));
    hazard_controller #(.MD_LAT(2)) dut2 (.clk(clk), .rst(rst), .h(h2.slave));
    typedef struct {
        string       name;
        bit          sel;
        logic [9:0]  exp;
        logic [15:0] sc;
    } exp_t;
    exp_t q[$];
    event chk;
    int checks = 0;
    int errors = 0;
    bit tgt = 1'b0;
    logic [15:0] sc_exp[2];
    logic [9:0] out4, out2;
    assign out4 = {h4.ForwardAE, h4.ForwardBE, h4.StallF, h4.StallD, h4.StallE, h4.FlushD, h4.FlushE, h4.FlushM};
    assign out2 = {h2.ForwardAE, h2.ForwardBE, h2.StallF, h2.StallD, h2.StallE, h2.FlushD, h2.FlushE, h2.FlushM};

    // exp bits: {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM}
    task automatic vec(input string name, input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                       input logic rwm, rww, loade, pcsrc, mdstart, input logic [9:0] exp);
        if (tgt) begin
            h2.Rs1D = rs1d; h2.Rs2D = rs2d; h2.Rs1E = rs1e; h2.Rs2E = rs2e; h2.RdE = rde;
            h2.RdM = rdm; h2.RdW = rdw; h2.RegWriteM = rwm; h2.RegWriteW = rww;
            h2.LoadE = loade; h2.PCSrcE = pcsrc; h2.MDStartE = mdstart;
        end else begin
            h4.Rs1D = rs1d; h4.Rs2D = rs2d; h4.Rs1E = rs1e; h4.Rs2E = rs2e; h4.RdE = rde;
            h4.RdM = rdm; h4.RdW = rdw; h4.RegWriteM = rwm; h4.RegWriteW = rww;
            h4.LoadE = loade; h4.PCSrcE = pcsrc; h4.MDStartE = mdstart;
        end
        q.push_back('{name, tgt, exp, sc_exp[tgt]});
        if (exp[5]) sc_exp[tgt] = sc_exp[tgt] + 16'd1;
        -> chk;
        #2;
    endtask

    task automatic idle_all();
        h4.Rs1D = 0; h4.Rs2D = 0; h4.Rs1E = 0; h4.Rs2E = 0; h4.RdE = 0; h4.RdM = 0; h4.RdW = 0;
        h4.RegWriteM = 0; h4.RegWriteW = 0; h4.LoadE = 0; h4.PCSrcE = 0; h4.MDStartE = 0;
        h2.Rs1D = 0; h2.Rs2D = 0; h2.Rs1E = 0; h2.Rs2E = 0; h2.RdE = 0; h2.RdM = 0; h2.RdW = 0;
        h2.RegWriteM = 0; h2.RegWriteW = 0; h2.LoadE = 0; h2.PCSrcE = 0; h2.MDStartE = 0;
    endtask

    initial begin
        exp_t e;
        logic [9:0] act;
        logic [15:0] act_sc;
        forever begin
            @(chk);
            #1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: monitor fired with no expected entry");
            end else begin
                e = q.pop_front();
                act    = e.sel ? out2 : out4;
                act_sc = e.sel ? h2.StallCount : h4.StallCount;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s outputs: got %b expected %b", e.name, act, e.exp);
                end
                checks++;
                if (act_sc !== e.sc) begin
                    errors++;
                    $display("FAIL %s StallCount: got %0d expected %0d", e.name, act_sc, e.sc);
                end
            end
        end
    end

    initial begin
        sc_exp[0] = 16'd0;
        sc_exp[1] = 16'd0;
        idle_all();
        @(negedge clk);
        vec("in_reset", 5'd3, 5'd3, 5'd5, 5'd5, 5'd3, 5'd5, 5'd5, 1, 1, 1, 1, 1, 10'b00_00_000000);
        @(negedge clk); rst = 1'b1;
        vec("fwd_m",    0, 0, 5'd5, 0,    0, 5'd5, 5'd5, 1, 1, 0, 0, 0, 10'b10_00_000000);
        @(negedge clk);
        vec("fwd_w",    0, 0, 5'd5, 0,    0, 0,    5'd5, 1, 1, 0, 0, 0, 10'b01_00_000000);
        @(negedge clk);
        vec("fwd_b_m",  0, 0, 0,    5'd7, 0, 5'd7, 0,    1, 0, 0, 0, 0, 10'b00_10_000000);
        @(negedge clk);
        vec("fwd_nowe", 0, 0, 5'd7, 5'd7, 0, 5'd7, 5'd7, 0, 1, 0, 0, 0, 10'b01_01_000000);
        @(negedge clk);
        vec("lw",       0, 5'd3, 0, 0, 5'd3, 0, 0, 0, 0, 1, 0, 0, 10'b00_00_110010);
        @(negedge clk);
        vec("lw_rd0",   0, 0,    0, 0, 0,    0, 0, 0, 0, 1, 0, 0, 10'b00_00_000000);
        @(negedge clk);
        vec("br",       0, 0,    0, 0, 0,    0, 0, 0, 0, 0, 1, 0, 10'b00_00_000110);
        @(negedge clk);
        vec("br_lw",    5'd3, 0, 0, 0, 5'd3, 0, 0, 0, 0, 1, 1, 0, 10'b00_00_110110);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec($sformatf("md4_c%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                (i < 3) ? 10'b00_00_111001 : 10'b00_00_000000);
        end
        @(negedge clk);
        vec("md4_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b00_00_000000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec($sformatf("md4_haz_c%0d", i), 5'd3, 0, 0, 0, 5'd3, 0, 0, 0, 0, 1, 1, 1,
                (i < 3) ? 10'b00_00_111001 : 10'b00_00_110110);
        end
        @(negedge clk);
        vec("md4_haz_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b00_00_000000);
        @(negedge clk);
        vec("rst_c0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b00_00_111001);
        @(negedge clk);
        vec("rst_c1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b00_00_111001);
        #1 rst = 1'b0;
        sc_exp[0] = 16'd0;
        sc_exp[1] = 16'd0;
        vec("rst_async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b00_00_000000);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vec($sformatf("rst_resume_c%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                (i < 3) ? 10'b00_00_111001 : 10'b00_00_000000);
            @(negedge clk);
        end
        vec("rst_resume_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b00_00_000000);
        idle_all();
        tgt = 1'b1;
        @(negedge clk);
        vec("md2_c0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b00_00_111001);
        @(negedge clk);
        vec("md2_c1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b00_00_000000);
        @(negedge clk);
        vec("md2_again", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10'b00_00_111001);
        @(negedge clk);
        vec("md2_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b00_00_000000);
        #10;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
